// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the serial CORDIC blocks (rotator and vectoring).
//   state_t      : FSM state encoding
//   sat_t        : result of the saturation range check
//   atan_lut()   : round(atan(2^-i) * 2^phi_wdt / (2*pi)) for i = 0..31,
//                  valid for phi_wdt <= 31
//   inv_k()      : round(2^k_frac / 1.6467602581), valid for k_frac <= 31
//   sat_check()  : classifies a signed value against the unsigned range [0, 2^w-1]
// -----------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_LOW  = 2'd1,
    SAT_HIGH = 2'd2
  } sat_t;

  // 1/K (K = CORDIC gain 1.6467602581) as a 32-bit binary fraction.
  localparam logic [31:0] INV_K_FRAC32 = 32'd2608131496;

  // Arctangents in fractions of a full turn, scaled by 2^32. Narrower phase
  // scales are derived by rounding these down to the requested width.
  function automatic logic [31:0] atan_lut(input int unsigned i, input int unsigned phi_wdt);
    logic [31:0] t;
    logic [32:0] r;
    case (i)
      0:  t = 32'd536870912;
      1:  t = 32'd316933406;
      2:  t = 32'd167458907;
      3:  t = 32'd85004756;
      4:  t = 32'd42667331;
      5:  t = 32'd21354465;
      6:  t = 32'd10679838;
      7:  t = 32'd5340245;
      8:  t = 32'd2670163;
      9:  t = 32'd1335087;
      10: t = 32'd667544;
      11: t = 32'd333772;
      12: t = 32'd166886;
      13: t = 32'd83443;
      14: t = 32'd41722;
      15: t = 32'd20861;
      16: t = 32'd10430;
      17: t = 32'd5215;
      18: t = 32'd2608;
      19: t = 32'd1304;
      20: t = 32'd652;
      21: t = 32'd326;
      22: t = 32'd163;
      23: t = 32'd81;
      24: t = 32'd41;
      25: t = 32'd20;
      26: t = 32'd10;
      27: t = 32'd5;
      28: t = 32'd3;
      29: t = 32'd1;
      30: t = 32'd1;
      default: t = 32'd0;
    endcase
    r = {1'b0, t} + (33'd1 << (31 - phi_wdt));
    return 32'(r >> (32 - phi_wdt));
  endfunction

  function automatic logic [31:0] inv_k(input int unsigned k_frac);
    logic [32:0] r;
    r = {1'b0, INV_K_FRAC32} + (33'd1 << (31 - k_frac));
    return 32'(r >> (32 - k_frac));
  endfunction

  function automatic sat_t sat_check(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< w) - 64'sd1;
    if (v < 64'sd0)
      return SAT_LOW;
    else if (v > max_v)
      return SAT_HIGH;
    else
      return SAT_NONE;
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// -----------------------------------------------------------------------------
// cordic_atan_lut
// Combinational arctangent table for the serial CORDIC blocks.
// Ports:
//   ni   in  NI_WDT   iteration index
//   atan out PHI_WDT  atan(2^-ni) on the 0..2^PHI_WDT == 0..2*pi phase scale
// -----------------------------------------------------------------------------
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int PHI_WDT = 16,
  parameter int NI_WDT  = 4
) (
  input  logic [NI_WDT-1:0]  ni,
  output logic [PHI_WDT-1:0] atan
);

  assign atan = PHI_WDT'(atan_lut(32'(ni), PHI_WDT));

endmodule

// File: rtl/cordic_atan2_serial.sv
// -----------------------------------------------------------------------------
// cordic_atan2_serial
// Serial vectoring-mode CORDIC: returns phi = atan2(y, x) on an unsigned
// 0..2^PHI_WDT == [0, 2*pi) phase scale and the gain-compensated magnitude.
// One result every N+2 enabled clocks.
// Ports:
//   clk    in   1        clock
//   reset  in   1        asynchronous reset, active-high
//   sclr   in   1        synchronous clear (qualified by en)
//   en     in   1        clock enable, freezes every register when low
//   st     in   1        start: capture x, y (restarts a calculation in flight)
//   x, y   in   XY_WDT   signed Cartesian input
//   rdy    out  1        result valid / idle
//   phi    out  PHI_WDT  unsigned angle
//   mag    out  XY_WDT   unsigned magnitude, clamped to 2^XY_WDT-1
// -----------------------------------------------------------------------------
module cordic_atan2_serial
  import cordic_pkg::*;
#(
  parameter int N       = 16,
  parameter int XY_WDT  = 16,
  parameter int PHI_WDT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclr,
  input  logic                     en,
  input  logic                     st,
  input  logic signed [XY_WDT-1:0] x,
  input  logic signed [XY_WDT-1:0] y,
  output logic                     rdy,
  output logic [PHI_WDT-1:0]       phi,
  output logic [XY_WDT-1:0]        mag
);

  localparam int NI_WDT = (N > 2) ? $clog2(N) : 1;
  // Two guard bits: one for negating the most negative input, one for the
  // sqrt(2)*K growth of the vector during iteration.
  localparam int RW     = XY_WDT + 2;
  localparam int K_FRAC = XY_WDT + 2;
  localparam int PW     = RW + K_FRAC + 1;

  localparam logic signed [PW-1:0] INV_K_S    = PW'(inv_k(K_FRAC));
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (K_FRAC - 1);
  localparam logic [PHI_WDT-1:0]   PI_PHASE   = PHI_WDT'(1) << (PHI_WDT - 1);
  localparam logic [NI_WDT-1:0]    NI_LAST    = NI_WDT'(N - 1);

  state_t                 state;
  logic signed [RW-1:0]   xr;
  logic signed [RW-1:0]   yr;
  logic [PHI_WDT-1:0]     z;       // phase accumulator, wraps mod 2^PHI_WDT
  logic [NI_WDT-1:0]      ni;
  logic                   zero_in; // x = y = 0: the angle is undefined, report 0

  logic [PHI_WDT-1:0]     atan;
  logic signed [RW-1:0]   x_ext;
  logic signed [RW-1:0]   y_ext;
  logic signed [RW-1:0]   xs;
  logic signed [RW-1:0]   ys;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   scaled;
  logic [XY_WDT-1:0]      mag_next;

  cordic_atan_lut #(
    .PHI_WDT (PHI_WDT),
    .NI_WDT  (NI_WDT)
  ) u_atan_lut (
    .ni   (ni),
    .atan (atan)
  );

  // Inputs widened before any negation so that x = -2^(XY_WDT-1) negates exactly.
  assign x_ext = RW'(x);
  assign y_ext = RW'(y);
  assign xs    = xr >>> ni;
  assign ys    = yr >>> ni;

  // NOTE: every variable driven in an always_comb gets a value on every path
  // (here: unconditionally first), otherwise a latch is inferred.
  always_comb begin
    prod     = PW'(xr) * INV_K_S;
    scaled   = (prod + ROUND_HALF) >>> K_FRAC;
    mag_next = scaled[XY_WDT-1:0];
    case (sat_check(64'(scaled), XY_WDT))
      SAT_LOW:  mag_next = '0;
      SAT_HIGH: mag_next = '1;
      default:  mag_next = scaled[XY_WDT-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rdy     <= 1'b0;
      phi     <= '0;
      mag     <= '0;
      xr      <= '0;
      yr      <= '0;
      z       <= '0;
      ni      <= '0;
      zero_in <= 1'b0;
    end else if (en) begin
      if (sclr) begin
        state <= IDLE;
        rdy   <= 1'b0;
        phi   <= '0;
        mag   <= '0;
      end else if (st) begin
        state   <= ITER;
        rdy     <= 1'b0;
        ni      <= '0;
        zero_in <= (x == '0) && (y == '0);
        // Left half-plane inputs are rotated by pi so the iterations only
        // ever have to cover +/- pi/2.
        if (x < 0) begin
          xr <= -x_ext;
          yr <= -y_ext;
          z  <= PI_PHASE;
        end else begin
          xr <= x_ext;
          yr <= y_ext;
          z  <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            rdy <= 1'b1;
          end
          ITER: begin
            // Rotate towards the x axis; z accumulates the angle removed.
            if (yr >= 0) begin
              xr <= xr + ys;
              yr <= yr - xs;
              z  <= z + atan;
            end else begin
              xr <= xr - ys;
              yr <= yr + xs;
              z  <= z - atan;
            end
            if (ni == NI_LAST)
              state <= SCALE;
            else
              ni <= ni + 1'b1;
          end
          SCALE: begin
            phi   <= zero_in ? '0 : z;
            mag   <= mag_next;
            rdy   <= 1'b1;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
